spi_frame_controller: RTL and testbench

Sequences the SPI slave receive path into memory-mapped writes. Consumes completed bytes from the SPI slave, parses a fixed frame format (command, address, length, payload), and issues one valid/ready write per payload byte with auto-incrementing address. Sits between the SPI slave and the on-chip register/memory write port; it is the only consumer of the slave's byte stream.

---
 rtl/spi_pkg.sv | 29 ++
 rtl/spi_frame_controller_if.sv | 39 +++
 rtl/spi_byte_fifo.sv | 68 ++++++
 rtl/spi_frame_controller.sv | 197 +++++++++++++++++++
 tb/tb_spi_frame_controller.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI frame controller slice.
//   parser_state_t : frame parser states (ST_CHECK is only reached when the
//                    design is built with SPI_FRAME_CHECKSUM_EN defined)
//   CMD_WRITE      : the only command byte the parser accepts
//   FRAME_OFS_*    : byte offsets of the fixed frame fields
// ---------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LEN,
    ST_PAYLOAD,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } parser_state_t;

  localparam logic [7:0] CMD_WRITE = 8'hA5;

  localparam int FRAME_OFS_CMD     = 0;
  localparam int FRAME_OFS_ADDR    = 1;
  localparam int FRAME_OFS_LEN     = 2;
  localparam int FRAME_OFS_PAYLOAD = 3;

endpackage

// File: rtl/spi_frame_controller_if.sv
// ---------------------------------------------------------------------------
// spi_frame_controller_if
// Bundles the byte stream from the SPI slave, the memory write port and the
// frame status outputs of spi_frame_controller.
//   slave  modport : controller side (consumes bytes, drives the write port)
//   master modport : environment side (SPI slave + memory + status observer)
// Signals:
//   io_byteValid / io_byte   : completed-byte strobe and data
//   io_ssActive              : slave select asserted
//   io_memWriteValid/Ready   : write handshake, io_memAddress/io_memWriteData
//   io_frameDone/io_frameError : one-cycle frame outcome pulses
//   io_busy                  : parser active or bytes buffered
// ---------------------------------------------------------------------------
interface spi_frame_controller_if #(
  parameter int ADDR_W = 8
);
  logic              io_byteValid;
  logic [7:0]        io_byte;
  logic              io_ssActive;
  logic              io_memWriteValid;
  logic [ADDR_W-1:0] io_memAddress;
  logic [7:0]        io_memWriteData;
  logic              io_memWriteReady;
  logic              io_frameDone;
  logic              io_frameError;
  logic              io_busy;

  modport slave (
    input  io_byteValid, io_byte, io_ssActive, io_memWriteReady,
    output io_memWriteValid, io_memAddress, io_memWriteData,
           io_frameDone, io_frameError, io_busy
  );

  modport master (
    output io_byteValid, io_byte, io_ssActive, io_memWriteReady,
    input  io_memWriteValid, io_memAddress, io_memWriteData,
           io_frameDone, io_frameError, io_busy
  );
endinterface

// File: rtl/spi_byte_fifo.sv
// ---------------------------------------------------------------------------
// spi_byte_fifo
// Small synchronous byte FIFO with show-ahead read data.
//   clock, reset : system clock, asynchronous active-high reset
//   i_push/i_data: write strobe and byte; ignored when full unless a pop
//                  happens in the same cycle
//   i_pop        : consume o_data (ignored when empty)
//   i_flush      : discard all contents; wins over push and pop
//   o_data       : byte at the head of the FIFO
//   o_empty/o_full : occupancy flags
// ---------------------------------------------------------------------------
module spi_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  input  logic       i_flush,
  output logic [7:0] o_data,
  output logic       o_empty,
  output logic       o_full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  // A pop frees the slot in the same cycle, so a full FIFO may still accept.
  assign w_pop   = i_pop && !o_empty && !i_flush;
  assign w_push  = i_push && !i_flush && (!o_full || w_pop);
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/spi_frame_controller.sv
// ---------------------------------------------------------------------------
// spi_frame_controller
// Turns the SPI slave byte stream into memory writes. Frame layout:
//   CMD_WRITE, base address, length N, N payload bytes
//   (+ one XOR checksum byte when SPI_FRAME_CHECKSUM_EN is defined)
// Each payload byte becomes one valid/ready write at an auto-incrementing
// address.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   bus          : spi_frame_controller_if.slave (byte stream in, write port
//                  and frameDone/frameError/busy out)
// Optional feature macro: SPI_FRAME_CHECKSUM_EN (adds the CHECK state).
// ---------------------------------------------------------------------------
module spi_frame_controller
  import spi_pkg::*;
#(
  parameter int         ADDR_W     = 8,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] CMD_WRITE  = spi_pkg::CMD_WRITE
) (
  input  logic                  clock,
  input  logic                  reset,
  spi_frame_controller_if.slave bus
);
`ifdef SPI_FRAME_CHECKSUM_EN
  localparam bit CHECKSUM_EN = 1'b1;
`else
  localparam bit CHECKSUM_EN = 1'b0;
`endif

  parser_state_t     r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_data;
  logic [7:0]        r_remaining;
  logic              r_valid;
  logic              r_done;
  logic              r_error;
  logic              r_ss_prev;
  logic              r_released;
  logic              r_overflow;
`ifdef SPI_FRAME_CHECKSUM_EN
  logic [7:0]        r_xor;
`endif

  logic       w_empty;
  logic       w_full;
  logic [7:0] w_rd_data;
  logic       w_step;
  logic       w_abort;
  logic       w_pop;
  logic       w_flush;
  logic       w_ss_fall;
  logic       w_to_idle;

  // States that consume a byte; overflow and truncation are only acted upon
  // here so an issued write is always allowed to complete.
  assign w_step    = (r_state == ST_IDLE) || (r_state == ST_ADDR) || (r_state == ST_LEN) ||
                     (r_state == ST_PAYLOAD) || (r_state == ST_CHECK);
  // Truncation needs an empty FIFO, so bytes buffered before SS release drain first.
  assign w_abort   = w_step && (r_overflow ||
                     ((r_state != ST_IDLE) && w_empty && r_released));
  assign w_pop     = w_step && !w_abort && !w_empty;
  assign w_flush   = (r_state == ST_ERROR);
  assign w_ss_fall = r_ss_prev && !bus.io_ssActive;
  assign w_to_idle = (r_state == ST_DONE) || ((r_state == ST_ERROR) && !bus.io_ssActive);

  spi_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (bus.io_byteValid),
    .i_data  (bus.io_byte),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_data  (w_rd_data),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // Sticky overflow and SS-release tracking.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ss_prev  <= 1'b0;
      r_released <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_ss_prev <= bus.io_ssActive;
      // An idle parser with nothing buffered has no frame to truncate.
      if (w_to_idle || ((r_state == ST_IDLE) && w_empty)) begin
        r_released <= 1'b0;
      end else if (w_ss_fall) begin
        r_released <= 1'b1;
      end
      if (w_flush) begin
        r_overflow <= 1'b0;
      end else if (bus.io_byteValid && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_data      <= '0;
      r_remaining <= '0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
`ifdef SPI_FRAME_CHECKSUM_EN
      r_xor       <= '0;
`endif
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      if (w_abort) begin
        r_state <= ST_ERROR;
        r_error <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: if (w_pop) begin
            if (w_rd_data == CMD_WRITE) begin
              r_state <= ST_ADDR;
`ifdef SPI_FRAME_CHECKSUM_EN
              r_xor   <= w_rd_data;
`endif
            end else begin
              r_state <= ST_ERROR;
              r_error <= 1'b1;
            end
          end
          ST_ADDR: if (w_pop) begin
            r_addr  <= ADDR_W'(w_rd_data);
            r_state <= ST_LEN;
`ifdef SPI_FRAME_CHECKSUM_EN
            r_xor   <= r_xor ^ w_rd_data;
`endif
          end
          ST_LEN: if (w_pop) begin
            r_remaining <= w_rd_data;
`ifdef SPI_FRAME_CHECKSUM_EN
            r_xor       <= r_xor ^ w_rd_data;
`endif
            if (w_rd_data == 8'd0) begin
              r_state <= CHECKSUM_EN ? ST_CHECK : ST_DONE;
              r_done  <= !CHECKSUM_EN;
            end else begin
              r_state <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: if (w_pop) begin
            r_data  <= w_rd_data;
            r_valid <= 1'b1;
            r_state <= ST_WRITE;
`ifdef SPI_FRAME_CHECKSUM_EN
            r_xor   <= r_xor ^ w_rd_data;
`endif
          end
          ST_WRITE: if (bus.io_memWriteReady) begin
            r_valid     <= 1'b0;
            r_addr      <= r_addr + ADDR_W'(1);
            r_remaining <= r_remaining - 8'd1;
            if (r_remaining == 8'd1) begin
              r_state <= CHECKSUM_EN ? ST_CHECK : ST_DONE;
              r_done  <= !CHECKSUM_EN;
            end else begin
              r_state <= ST_PAYLOAD;
            end
          end
`ifdef SPI_FRAME_CHECKSUM_EN
          ST_CHECK: if (w_pop) begin
            if (w_rd_data == r_xor) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_ERROR;
              r_error <= 1'b1;
            end
          end
`endif
          ST_DONE:  r_state <= ST_IDLE;
          ST_ERROR: if (!bus.io_ssActive) r_state <= ST_IDLE;
          default:  r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.io_memWriteValid = r_valid;
  assign bus.io_memAddress    = r_addr;
  assign bus.io_memWriteData  = r_data;
  assign bus.io_frameDone     = r_done;
  assign bus.io_frameError    = r_error;
  assign bus.io_busy          = (r_state != ST_IDLE) || !w_empty;
endmodule

// File: tb/tb_spi_frame_controller.sv
// ---------------------------------------------------------------------------
// tb_spi_frame_controller
// Directed frames against spi_frame_controller. A frame-level model derives
// the expected write list and frame outcome from the frame bytes; a monitor
// compares every write handshake and hold cycle against it. Literal checks
// pin write values, address wrap, latency and reset behaviour.
// Honours SPI_FRAME_CHECKSUM_EN the same way the design does.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_frame_controller;
  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_frame_controller_if #(.ADDR_W(8)) bus();

  spi_frame_controller #(
    .ADDR_W     (8),
    .FIFO_DEPTH (4),
    .CMD_WRITE  (8'hA5)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] exp_q[$];   // {address, data} still owed by the DUT
  logic [15:0] log_q[$];   // {address, data} observed in the current test
  int exp_done = 0, exp_err = 0, obs_done = 0, obs_err = 0, obs_hs = 0;
  int strobe_cyc = 0, lat = -1, last_hs_cyc = 0, done_gap = -1;
  bit lat_armed = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual timeout required event", name);
  endtask

  // Frame-level reference: what a frame's bytes must produce.
  function automatic void model_frame(input bq_t f);
    logic [7:0] base;
    int n;
`ifdef SPI_FRAME_CHECKSUM_EN
    logic [7:0] x;
`endif
    if (f.size() == 0) return;
    if (f[0] != 8'hA5 || f.size() < 3) begin exp_err++; return; end
    base = f[1];
    n = int'(f[2]);
    for (int i = 0; i < n; i++) begin
      if (3 + i >= f.size()) begin exp_err++; return; end
      exp_q.push_back({8'(base + 8'(i)), f[3+i]});
    end
`ifdef SPI_FRAME_CHECKSUM_EN
    if (f.size() < 4 + n) begin exp_err++; return; end
    x = 8'h00;
    for (int i = 0; i < 3 + n; i++) x = x ^ f[i];
    if (f[3+n] != x) begin exp_err++; return; end
`endif
    exp_done++;
  endfunction

  function automatic bq_t with_ck(input bq_t f);
    bq_t r;
`ifdef SPI_FRAME_CHECKSUM_EN
    logic [7:0] x;
`endif
    r = f;
`ifdef SPI_FRAME_CHECKSUM_EN
    x = 8'h00;
    foreach (f[i]) x = x ^ f[i];
    r.push_back(x);
`endif
    return r;
  endfunction

  // Monitor: every write handshake, hold cycle and status pulse.
  initial begin
    logic       prev_v;
    logic       prev_r;
    logic [7:0] prev_a;
    logic [7:0] prev_d;
    logic [15:0] e;
    prev_v = 1'b0; prev_r = 1'b0; prev_a = 8'h00; prev_d = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0;
        prev_r = 1'b0;
      end else begin
        if (prev_v && !prev_r) begin
          check("hold_valid", 32'(bus.io_memWriteValid), 32'd1);
          check("hold_addr", 32'(bus.io_memAddress), 32'(prev_a));
          check("hold_data", 32'(bus.io_memWriteData), 32'(prev_d));
        end
        if (bus.io_memWriteValid && lat_armed) begin
          lat = cyc - strobe_cyc;
          lat_armed = 1'b0;
        end
        if (bus.io_memWriteValid && bus.io_memWriteReady) begin
          obs_hs++;
          last_hs_cyc = cyc;
          log_q.push_back({bus.io_memAddress, bus.io_memWriteData});
          $display("write addr %02h data %02h", bus.io_memAddress, bus.io_memWriteData);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: actual addr %02h data %02h required none",
                     bus.io_memAddress, bus.io_memWriteData);
          end else begin
            e = exp_q.pop_front();
            check("write_addr", 32'(bus.io_memAddress), 32'(e[15:8]));
            check("write_data", 32'(bus.io_memWriteData), 32'(e[7:0]));
          end
        end
        if (bus.io_frameDone) begin
          obs_done++;
          done_gap = cyc - last_hs_cyc;
        end
        if (bus.io_frameError) obs_err++;
        if (bus.io_frameDone && bus.io_frameError) begin
          check("done_and_error", 32'd1, 32'd0);
        end
        prev_v = bus.io_memWriteValid;
        prev_r = bus.io_memWriteReady;
        prev_a = bus.io_memAddress;
        prev_d = bus.io_memWriteData;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    bus.io_byte = b;
    bus.io_byteValid = 1'b1;
    strobe_cyc = cyc;
    @(posedge clk);
    #1;
    bus.io_byteValid = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_frame(input bq_t f, input bit arm);
    foreach (f[i]) begin
      if (arm && i == 3) lat_armed = 1'b1;
      send_byte(f[i]);
    end
  endtask

  // Hold ready low across the second write of the frame.
  task automatic stall_second(input int hs0);
    int k;
    for (k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      if (obs_hs >= hs0 + 1) break;
    end
    if (k == 300) timeout("stall_first_write");
    bus.io_memWriteReady = 1'b0;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.io_memWriteValid) break;
    end
    if (k == 300) timeout("stall_second_valid");
    repeat (2) @(negedge clk);
    check("stall_addr", 32'(bus.io_memAddress), 32'h11);
    check("stall_data", 32'(bus.io_memWriteData), 32'h22);
    repeat (3) @(posedge clk);
    #1;
    bus.io_memWriteReady = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!bus.io_busy && !bus.io_memWriteValid) break;
    end
    if (k == 300) timeout({name, "_idle"});
  endtask

  task automatic run_frame(input string name, input bq_t f, input bit early_release,
                           input bit arm, input bit stall);
    int hs0;
    log_q.delete();
    model_frame(f);
    hs0 = obs_hs;
    @(posedge clk);
    #1;
    bus.io_ssActive = 1'b1;
    repeat (2) @(posedge clk);
    fork
      send_frame(f, arm);
      if (stall) stall_second(hs0);
    join
    if (!early_release) repeat (40) @(posedge clk);
    #1;
    bus.io_ssActive = 1'b0;
    wait_idle(name);
    repeat (3) @(negedge clk);
    check({name, "_done_count"}, 32'(obs_done), 32'(exp_done));
    check({name, "_error_count"}, 32'(obs_err), 32'(exp_err));
    check({name, "_missing_writes"}, 32'(exp_q.size()), 32'd0);
    $display("frame %s: writes %0d done %0d error %0d", name, log_q.size(), obs_done, obs_err);
  endtask

  initial begin
    bq_t f;
    int k;
    bus.io_byteValid = 1'b0;
    bus.io_byte = 8'h00;
    bus.io_ssActive = 1'b0;
    bus.io_memWriteReady = 1'b1;

    #2;
    check("rst_valid", 32'(bus.io_memWriteValid), 32'd0);
    check("rst_addr", 32'(bus.io_memAddress), 32'd0);
    check("rst_data", 32'(bus.io_memWriteData), 32'd0);
    check("rst_done", 32'(bus.io_frameDone), 32'd0);
    check("rst_error", 32'(bus.io_frameError), 32'd0);
    check("rst_busy", 32'(bus.io_busy), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic frame, ready high.
    f = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33};
    run_frame("basic", with_ck(f), 1'b0, 1'b1, 1'b0);
    check("basic_nwrites", 32'(log_q.size()), 32'd3);
    if (log_q.size() == 3) begin
      check("basic_w0", 32'(log_q[0]), 32'h1011);
      check("basic_w1", 32'(log_q[1]), 32'h1122);
      check("basic_w2", 32'(log_q[2]), 32'h1233);
    end
    check("first_write_latency", 32'(lat), 32'd2);
`ifndef SPI_FRAME_CHECKSUM_EN
    check("done_after_last_write", 32'(done_gap), 32'd1);
`endif

    // Same frame with the second write stalled.
    run_frame("stall", with_ck(f), 1'b0, 1'b0, 1'b1);
    check("stall_nwrites", 32'(log_q.size()), 32'd3);

    // Address wrap.
    f = '{8'hA5, 8'hFE, 8'h03, 8'h01, 8'h02, 8'h03};
    run_frame("wrap", with_ck(f), 1'b0, 1'b0, 1'b0);
    check("wrap_nwrites", 32'(log_q.size()), 32'd3);
    if (log_q.size() == 3) begin
      check("wrap_a0", 32'(log_q[0][15:8]), 32'hFE);
      check("wrap_a1", 32'(log_q[1][15:8]), 32'hFF);
      check("wrap_a2", 32'(log_q[2][15:8]), 32'h00);
    end

    // Bad command, then a good frame after an SS cycle.
    f = '{8'h3C, 8'h10, 8'h03};
    run_frame("badcmd", f, 1'b0, 1'b0, 1'b0);
    check("badcmd_nwrites", 32'(log_q.size()), 32'd0);
    f = '{8'hA5, 8'h30, 8'h01, 8'h5C};
    run_frame("recover", with_ck(f), 1'b0, 1'b0, 1'b0);
    check("recover_nwrites", 32'(log_q.size()), 32'd1);

    // Truncated by SS release.
    f = '{8'hA5, 8'h20, 8'h04, 8'hAA, 8'hBB};
    run_frame("trunc", f, 1'b1, 1'b0, 1'b0);
    check("trunc_nwrites", 32'(log_q.size()), 32'd2);

`ifdef SPI_FRAME_CHECKSUM_EN
    f = '{8'hA5, 8'h00, 8'h01, 8'h5A, 8'hFE};
    run_frame("ck_good", f, 1'b0, 1'b0, 1'b0);
    check("ck_good_nwrites", 32'(log_q.size()), 32'd1);
    f = '{8'hA5, 8'h00, 8'h01, 8'h5A, 8'h00};
    run_frame("ck_bad", f, 1'b0, 1'b0, 1'b0);
    check("ck_bad_nwrites", 32'(log_q.size()), 32'd1);
`endif

    // Asynchronous reset while a write is pending.
    log_q.delete();
    bus.io_memWriteReady = 1'b0;
    @(posedge clk);
    #1;
    bus.io_ssActive = 1'b1;
    f = '{8'hA5, 8'h40, 8'h02, 8'h77, 8'h88};
    send_frame(f, 1'b0);
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.io_memWriteValid) break;
    end
    if (k == 300) timeout("arst_wait_valid");
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(bus.io_memWriteValid), 32'd0);
    check("arst_addr", 32'(bus.io_memAddress), 32'd0);
    check("arst_busy", 32'(bus.io_busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.io_memWriteReady = 1'b1;
    bus.io_ssActive = 1'b0;
    repeat (20) @(posedge clk);
    check("arst_no_writes", 32'(log_q.size()), 32'd0);

    // Normal operation resumes after reset.
    f = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33};
    run_frame("after_rst", with_ck(f), 1'b0, 1'b0, 1'b0);
    check("after_rst_nwrites", 32'(log_q.size()), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
